// File: rtl/smm_sequencer.sv
// smm_sequencer: runs one 4x4 matrix job at a time through an external multiplier datapath.
// Latency: mm_load one cycle after accept, result presented LATENCY+2 cycles after the accept cycle.
// Backpressure: a single job in flight; the result is held until out_ready, and no job is accepted while busy.
module smm_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int BUSWIDTH  = DATAWIDTH * 16,
  parameter int LATENCY   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUSWIDTH-1:0] in_a,
  input  logic [BUSWIDTH-1:0] in_b,
  input  logic                in_sel,
  output logic                mm_load,
  output logic [BUSWIDTH-1:0] mm_a,
  output logic [BUSWIDTH-1:0] mm_b,
  output logic                mm_sel,
  input  logic [BUSWIDTH-1:0] mm_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUSWIDTH-1:0] out_c,
  output logic                out_sel,
  output logic                busy,
  output logic [15:0]         job_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter starts at LATENCY-1 in the ISSUE cycle so the capture edge lands
  // exactly LATENCY edges after the one that samples mm_load.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mm_load   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mm_load   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Job operand capture; operands stay on the datapath bus until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_a   <= '0;
      mm_b   <= '0;
      mm_sel <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      mm_a   <= in_a;
      mm_b   <= in_b;
      mm_sel <= in_sel;
    end
  end

  // Latency down-counter: loaded while issuing, counts down while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (state == ISSUE) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Result capture: a straight copy of the datapath output, held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_c   <= '0;
      out_sel <= 1'b0;
    end else if (state == WAIT && cnt == 8'd0) begin
      out_c   <= mm_c;
      out_sel <= mm_sel;
    end
  end

  // Completed-job counter, stepped on each output handshake and free to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_count <= 16'd0;
    end else if (state == DONE && out_ready) begin
      job_count <= job_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_smm_sequencer.sv
// tb_smm_sequencer: directed and random jobs against a timeline reference model.
// The multiplier datapath is modelled as a LATENCY-deep pipe that carries the true product
// only for the mm_load cycle and random garbage otherwise, so capture timing is exact.
module tb_smm_sequencer;

  localparam int DW = 8;
  localparam int BW = DW * 16;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_sel;
  logic          mm_load;
  logic [BW-1:0] mm_a;
  logic [BW-1:0] mm_b;
  logic          mm_sel;
  logic [BW-1:0] mm_c;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_c;
  logic          out_sel;
  logic          busy;
  logic [15:0]   job_count;

  smm_sequencer #(.DATAWIDTH(DW), .BUSWIDTH(BW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .mm_load(mm_load), .mm_a(mm_a), .mm_b(mm_b), .mm_sel(mm_sel), .mm_c(mm_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_sel(out_sel),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] rnd_bus();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Plain 4x4 matrix product, row-major, element arithmetic modulo 2^DW.
  function automatic logic [BW-1:0] matmul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic [DW-1:0] s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          s = s + a[(i*4+k)*DW +: DW] * b[(k*4+j)*DW +: DW];
        end
        r[(i*4+j)*DW +: DW] = s;
      end
    end
    return r;
  endfunction

  // Datapath model.
  logic [BW-1:0] pipe [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mm_load ? matmul(mm_a, mm_b) : rnd_bus();
  end
  assign mm_c = pipe[L-1];

  // Reference model: job age in edges since accept.
  bit            m_busy;
  int            m_age;
  logic [BW-1:0] m_a, m_b, m_c;
  logic          m_sel, m_csel;
  logic [15:0]   m_jc;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;
  int ld_cnt;
  int rise_cnt;
  int acc_q[$];
  int rise_q[$];
  bit prev_ov;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit acc_now;
    bit exp_ov;
    acc_now = in_valid && in_ready && !rst;
    if (acc_now) acc_q.push_back(cyc);
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 0; m_age = 0; m_a = '0; m_b = '0; m_sel = 0; m_jc = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_age = 1;
        m_a = in_a; m_b = in_b; m_sel = in_sel;
        m_c = matmul(in_a, in_b); m_csel = in_sel;
      end
    end else if (m_age >= L + 2) begin
      if (out_ready) begin
        m_busy = 0;
        m_jc   = m_jc + 16'd1;
      end
    end else begin
      m_age++;
    end
    #1;
    exp_ov = m_busy && (m_age == L + 2);
    chk("in_ready", BW'(in_ready), BW'(!m_busy));
    chk("busy", BW'(busy), BW'(m_busy));
    chk("mm_load", BW'(mm_load), BW'(m_busy && m_age == 1));
    chk("out_valid", BW'(out_valid), BW'(exp_ov));
    chk("job_count", BW'(job_count), BW'(m_jc));
    chk("mm_a", mm_a, m_a);
    chk("mm_b", mm_b, m_b);
    chk("mm_sel", BW'(mm_sel), BW'(m_sel));
    if (exp_ov) begin
      chk("out_c", out_c, m_c);
      chk("out_sel", BW'(out_sel), BW'(m_csel));
    end
    if (rst) begin
      chk("rst_out_c", out_c, '0);
      chk("rst_out_sel", BW'(out_sel), '0);
    end
    if (mm_load) ld_cnt++;
    if (out_valid && !prev_ov) begin
      rise_cnt++;
      rise_q.push_back(cyc);
    end
    prev_ov = out_valid;
  endtask

  task automatic drain(input int n);
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [BW-1:0] ident, seq16, held_c;
  int            acc0;

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; in_a = '0; in_b = '0; in_sel = 0;
    m_busy = 0; m_age = 0; m_a = '0; m_b = '0; m_c = '0; m_sel = 0; m_csel = 0; m_jc = '0;
    prev_ov = 0; ld_cnt = 0; rise_cnt = 0;

    // Reset state.
    @(negedge clk);
    tick(); tick();
    rst = 0;
    tick();

    // Identity times 1..16 returns the second operand.
    ident = '0; seq16 = '0;
    for (int i = 0; i < 16; i++) begin
      seq16[i*DW +: DW] = DW'(i + 1);
      if (i % 5 == 0) ident[i*DW +: DW] = DW'(1);
    end
    acc_q.delete(); rise_q.delete(); ld_cnt = 0;
    in_a = ident; in_b = seq16; in_sel = 0; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0; in_a = rnd_bus(); in_b = rnd_bus();
    for (int i = 0; i < 10; i++) tick();
    chk("basic_loads", BW'(ld_cnt), BW'(1));
    chk("basic_rise_n", BW'(rise_q.size()), BW'(1));
    if (acc_q.size() == 1 && rise_q.size() == 1)
      chk("basic_rise_lat", BW'(rise_q[0] - acc_q[0]), BW'(L + 2));
    chk("basic_jc", BW'(job_count), BW'(1));

    // Output backpressure held for 10 cycles in DONE.
    in_a = rnd_bus(); in_b = rnd_bus(); in_sel = 0; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    for (int i = 0; i < 20 && !(m_busy && m_age == L + 2); i++) tick();
    chk("bp_reached_done", BW'(out_valid), BW'(1));
    held_c = out_c;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = rnd_bus();
      tick();
    end
    in_valid = 0;
    chk("bp_held_c", out_c, held_c);
    chk("bp_valid", BW'(out_valid), BW'(1));
    out_ready = 1;
    tick();
    tick();
    chk("bp_idle", BW'(in_ready), BW'(1));

    // Mode bit follows the job.
    in_a = rnd_bus(); in_b = rnd_bus(); in_sel = 1; in_valid = 1;
    tick();
    in_valid = 0; in_sel = 0;
    for (int i = 0; i < L + 1; i++) tick();
    chk("mode_out_sel", BW'(out_sel), BW'(1));
    drain(3);

    // Reset while waiting with the counter at 2.
    in_a = rnd_bus(); in_b = rnd_bus(); in_sel = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    rst = 1;
    rise_cnt = 0;
    tick();
    chk("rstw_mm_a", mm_a, '0);
    rst = 0;
    tick();
    chk("rstw_ready", BW'(in_ready), BW'(1));
    for (int i = 0; i < 10; i++) tick();
    chk("rstw_no_valid", BW'(rise_cnt), BW'(0));
    chk("rstw_jc", BW'(job_count), BW'(0));

    // Three back-to-back jobs with in_valid held high.
    acc_q.delete(); ld_cnt = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 60 && acc_q.size() < 3; i++) begin
      in_a = rnd_bus(); in_b = rnd_bus(); in_sel = 1'($urandom);
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < L + 4; i++) tick();
    chk("tput_accepts", BW'(acc_q.size()), BW'(3));
    if (acc_q.size() == 3) begin
      chk("tput_gap1", BW'(acc_q[1] - acc_q[0]), BW'(L + 3));
      chk("tput_gap2", BW'(acc_q[2] - acc_q[1]), BW'(L + 3));
    end
    chk("tput_loads", BW'(ld_cnt), BW'(3));
    chk("tput_jc", BW'(job_count), BW'(3));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = rnd_bus(); in_b = rnd_bus(); in_sel = 1'($urandom);
      tick();
    end
    drain(L + 4);

    // Completed-job counter wraps.
    force dut.job_count = 16'hFFFF;
    m_jc = 16'hFFFF;
    tick();
    release dut.job_count;
    tick();
    chk("wrap_preload", BW'(job_count), BW'(16'hFFFF));
    in_a = rnd_bus(); in_b = rnd_bus(); in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < L + 4; i++) tick();
    chk("wrap_jc", BW'(job_count), BW'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
